// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, reads the async instruction ROM and
// buffers {pc, instr} pairs in a small FIFO ahead of the IF/ID register.
module if_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          DEPTH    = 4,
    parameter int          AW       = 2,
    parameter int          IM_AW    = 10
) (
    input  logic             clk,
    input  logic             rst,
    output logic [IM_AW-1:0] im_addr,
    input  logic [31:0]      im_data,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    input  logic             id_ready,
    output logic             out_valid,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic [AW:0]      occupancy
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   mem_pc    [DEPTH];
    logic [31:0]   mem_instr [DEPTH];
    logic          pop;
    logic          push;

    assign im_addr   = fetch_pc[IM_AW+1:2];
    assign out_valid = (occupancy != '0);

    // A redirect blocks both ends: the buffer is about to be flushed anyway.
    assign pop  = out_valid & id_ready & ~redirect_valid;
    assign push = ~redirect_valid & ((occupancy != FULL) | pop);

    // Head is gated to zero when empty so stale storage never leaks out.
    assign out_pc    = out_valid ? mem_pc[rd_ptr]    : '0;
    assign out_instr = out_valid ? mem_instr[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else if (redirect_valid) begin
            fetch_pc  <= redirect_pc & 32'hFFFF_FFFC;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
                wr_ptr   <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            occupancy <= occupancy + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // Storage carries no reset; entries only become visible through occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]    <= fetch_pc;
            mem_instr[wr_ptr] <= im_data;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: behavioural ROM, queue-based reference model,
// plus explicit checks of the key latency/redirect/reset points.
module tb_if_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int IM_AW = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [IM_AW-1:0] im_addr;
    logic [31:0]      im_data;
    logic             redirect_valid = 1'b0;
    logic [31:0]      redirect_pc = '0;
    logic             id_ready = 1'b0;
    logic             out_valid;
    logic [31:0]      out_pc;
    logic [31:0]      out_instr;
    logic [AW:0]      occupancy;

    int vectors     = 0;
    int miscompares = 0;

    logic [63:0] sb [$];
    logic [31:0] mpc;
    bit          model_live = 0;

    if_fetch_queue #(
        .RESET_PC(RESET_PC), .DEPTH(DEPTH), .AW(AW), .IM_AW(IM_AW)
    ) dut (
        .clk(clk), .rst(rst), .im_addr(im_addr), .im_data(im_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_ready(id_ready), .out_valid(out_valid), .out_pc(out_pc),
        .out_instr(out_instr), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // ROM contents: im[k] = k + 0x100
    assign im_data = 32'h100 + {22'b0, im_addr};

    function automatic logic [31:0] rom(input logic [31:0] pc);
        return 32'h100 + ((pc >> 2) & 32'h3FF);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check outputs against the model, then advance the model.
    task automatic step(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        logic [63:0] head;
        bit          do_pop;
        @(negedge clk);
        rst = r; redirect_valid = rv; redirect_pc = rpc; id_ready = rdy;
        #1;
        if (model_live) begin
            chk("sb_valid", {31'b0, out_valid}, {31'b0, sb.size() != 0});
            chk("sb_occ", {29'b0, occupancy}, 32'(sb.size()));
            chk("sb_im_addr", {22'b0, im_addr}, (mpc >> 2) & 32'h3FF);
            if (sb.size() != 0) begin
                head = sb[0];
                chk("sb_pc", out_pc, head[63:32]);
                chk("sb_instr", out_instr, head[31:0]);
            end else begin
                chk("sb_pc_empty", out_pc, 32'h0);
                chk("sb_instr_empty", out_instr, 32'h0);
            end
        end
        if (r) begin
            sb.delete();
            mpc = RESET_PC;
            model_live = 1;
        end else if (rv) begin
            sb.delete();
            mpc = {rpc[31:2], 2'b00};
        end else begin
            do_pop = (sb.size() != 0) && rdy;
            if (do_pop) head = sb.pop_front();
            if (sb.size() < DEPTH) begin
                sb.push_back({mpc, rom(mpc)});
                mpc = mpc + 32'd4;
            end
        end
        @(posedge clk);
    endtask

    initial begin
        // Reset state
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        #1;
        chk("rst_valid", {31'b0, out_valid}, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_occ", {29'b0, occupancy}, 0);
        chk("rst_im_addr", {22'b0, im_addr}, 0);

        // Streaming at one per cycle
        step(0, 0, 0, 1);
        #1;
        chk("stream_pc0", out_pc, 32'h3000);
        chk("stream_instr0", out_instr, 32'h100);
        step(0, 0, 0, 1);
        #1;
        chk("stream_pc1", out_pc, 32'h3004);
        chk("stream_instr1", out_instr, 32'h101);
        chk("stream_occ", {29'b0, occupancy}, 1);
        repeat (4) step(0, 0, 0, 1);

        // Stall until full, then drain with simultaneous push/pop
        step(1, 0, 0, 0);
        repeat (6) step(0, 0, 0, 0);
        #1;
        chk("full_occ", {29'b0, occupancy}, 4);
        chk("full_im_addr", {22'b0, im_addr}, 32'h004);
        chk("full_head", out_pc, 32'h3000);
        for (int i = 1; i <= 6; i++) begin
            step(0, 0, 0, 1);
            #1;
            chk("drain_pc", out_pc, 32'h3000 + 32'(4 * i));
            chk("drain_occ", {29'b0, occupancy}, 4);
        end

        // Redirect with three entries buffered and id_ready high
        step(1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        step(0, 1, 32'h3043, 1);
        #1;
        chk("redir_valid", {31'b0, out_valid}, 0);
        chk("redir_occ", {29'b0, occupancy}, 0);
        step(0, 0, 0, 1);
        #1;
        chk("redir_pc", out_pc, 32'h3040);
        chk("redir_instr", out_instr, 32'h110);
        repeat (3) step(0, 0, 0, 1);

        // Back-to-back redirects: last one wins
        step(0, 1, 32'h3100, 1);
        step(0, 1, 32'h3200, 1);
        step(0, 0, 0, 1);
        #1;
        chk("b2b_pc", out_pc, 32'h3200);
        chk("b2b_instr", out_instr, rom(32'h3200));
        repeat (2) step(0, 0, 0, 1);

        // Mid-stream reset with two entries buffered
        step(0, 1, 32'h3500, 0);
        repeat (2) step(0, 0, 0, 0);
        step(1, 0, 0, 1);
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 0);
        chk("mid_rst_pc", out_pc, 0);
        chk("mid_rst_occ", {29'b0, occupancy}, 0);
        chk("mid_rst_im_addr", {22'b0, im_addr}, 0);
        step(0, 0, 0, 1);
        #1;
        chk("mid_rst_after", out_pc, 32'h3000);

        // Reset together with a redirect: reset has priority
        step(1, 1, 32'h3800, 1);
        step(0, 0, 0, 1);
        #1;
        chk("rst_over_redir", out_pc, 32'h3000);

        // Mixed random traffic checked by the model
        for (int i = 0; i < 200; i++) begin
            logic rv;
            rv = ($urandom_range(0, 15) == 0);
            step(0, rv, 32'h3000 + $urandom_range(0, 1023), 1'($urandom_range(0, 1)));
        end
        step(0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
